// File: rtl/sample_axi_pkg.sv
// Shared definitions for the sample-to-AXI writer.
// Holds the sample and sequence widths, the AXI OKAY response code, the
// writer FSM state type, and the helper that packs a ring word.
package sample_axi_pkg;

   localparam int SAMPLE_W = 14;
   localparam int SEQ_W    = 18;
   localparam int WORD_W   = SEQ_W + SAMPLE_W;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_RESP = 2'd2
   } wr_state_e;

   // Ring word layout: sequence number in the upper bits, sample in the lower.
   function automatic logic [WORD_W-1:0] pack_word(input logic [SEQ_W-1:0]    seq,
                                                   input logic [SAMPLE_W-1:0] sample);
      return {seq, sample};
   endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO for packed {seq, sample} words.
// Ports:
//   clk, reset        - clock and synchronous active-high reset (flushes)
//   push, wr_data     - write request and data
//   pop, rd_data      - read request; rd_data shows the head entry
//   full, empty, count - occupancy status
// A push while full is accepted when a pop happens in the same cycle.
module sample_fifo #(
   parameter  int DEPTH = 8,
   parameter  int WIDTH = 32,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign do_pop  = pop && (count_q != '0);
   assign do_push = push && (!count_q[AW] || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // DEPTH is a power of two, so the count MSB alone marks full.
   assign full    = count_q[AW];
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/sample_axi_writer.sv
// Captures strobed 14-bit samples into a FIFO and writes each one as a
// 32-bit word {seq, sample} over AXI4-Lite into a circular buffer.
// Ports:
//   clock_50, reset                - clock, synchronous active-high reset
//   enable, sample_valid, sample_data - sample capture
//   clear_status                   - clears overflow / bus_error
//   awaddr/awvalid/awready         - AXI write address channel
//   wdata/wstrb/wvalid/wready      - AXI write data channel
//   bresp/bvalid/bready            - AXI write response channel
//   overflow, bus_error, busy      - status
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | nothing in flight, waiting for the FIFO to become non-empty
// ST_XFER | awvalid/wvalid raised, each waiting for its own handshake
// ST_RESP | both handshakes done, bready high, waiting for bvalid
module sample_axi_writer
   import sample_axi_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int          RING_WORDS = 1024,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic                clock_50,
   input  logic                reset,
   input  logic                enable,
   input  logic                sample_valid,
   input  logic [SAMPLE_W-1:0] sample_data,
   input  logic                clear_status,
   output logic [31:0]         awaddr,
   output logic                awvalid,
   input  logic                awready,
   output logic [31:0]         wdata,
   output logic [3:0]          wstrb,
   output logic                wvalid,
   input  logic                wready,
   input  logic [1:0]          bresp,
   input  logic                bvalid,
   output logic                bready,
   output logic                overflow,
   output logic                bus_error,
   output logic                busy
);

   localparam int IDX_W = $clog2(RING_WORDS);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   wr_state_e         state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [SEQ_W-1:0]  seq_q, seq_d;
   logic [31:0]       awaddr_q, awaddr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              awvalid_q, awvalid_d;
   logic              wvalid_q, wvalid_d;
   logic              bready_q, bready_d;
   logic              overflow_q, overflow_d;
   logic              bus_error_q, bus_error_d;
   logic              busy_q, busy_d;

   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [WORD_W-1:0] fifo_rd_data;
   logic [CNT_W-1:0]  fifo_count, fifo_count_nxt;
   logic              sample_in, sample_drop, bus_err_set;

   function automatic logic [31:0] ring_addr(input logic [IDX_W-1:0] idx);
      return BASE_ADDR + {{(30-IDX_W){1'b0}}, idx, 2'b00};
   endfunction

   sample_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (WORD_W)
   ) u_fifo (
      .clk     (clock_50),
      .reset   (reset),
      .push    (fifo_push),
      .wr_data (pack_word(seq_q, sample_data)),
      .pop     (fifo_pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // A full FIFO still takes the sample if the FSM pops the head this cycle.
   assign sample_in   = sample_valid && enable;
   assign fifo_push   = sample_in && (!fifo_full || fifo_pop);
   assign sample_drop = sample_in && fifo_full && !fifo_pop;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      awaddr_d    = awaddr_q;
      wdata_d     = wdata_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      fifo_pop    = 1'b0;
      bus_err_set = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               awaddr_d  = ring_addr(idx_q);
               wdata_d   = fifo_rd_data;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               state_d   = ST_XFER;
            end
         end
         ST_XFER: begin
            if (awvalid_q && awready) begin
               awvalid_d = 1'b0;
            end
            if (wvalid_q && wready) begin
               wvalid_d = 1'b0;
            end
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = ST_RESP;
            end
         end
         ST_RESP: begin
            if (bvalid) begin
               bus_err_set = (bresp != AXI_RESP_OKAY);
               // The slot is consumed even on an error response.
               idx_d    = idx_q + IDX_W'(1);
               bready_d = 1'b0;
               if (!fifo_empty) begin
                  fifo_pop  = 1'b1;
                  awaddr_d  = ring_addr(idx_d);
                  wdata_d   = fifo_rd_data;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = ST_XFER;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign seq_d          = fifo_push ? seq_q + SEQ_W'(1) : seq_q;
   assign fifo_count_nxt = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
   assign busy_d         = (state_d != ST_IDLE) || (fifo_count_nxt != '0);

   // Set events take priority over a simultaneous clear.
   assign overflow_d  = sample_drop | (overflow_q & ~clear_status);
   assign bus_error_d = bus_err_set | (bus_error_q & ~clear_status);

   always_ff @(posedge clock_50) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         seq_q       <= '0;
         awaddr_q    <= BASE_ADDR;
         wdata_q     <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         overflow_q  <= 1'b0;
         bus_error_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         seq_q       <= seq_d;
         awaddr_q    <= awaddr_d;
         wdata_q     <= wdata_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         overflow_q  <= overflow_d;
         bus_error_q <= bus_error_d;
         busy_q      <= busy_d;
      end
   end

   assign awaddr    = awaddr_q;
   assign awvalid   = awvalid_q;
   assign wdata     = wdata_q;
   assign wstrb     = 4'hF;
   assign wvalid    = wvalid_q;
   assign bready    = bready_q;
   assign overflow  = overflow_q;
   assign bus_error = bus_error_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_sample_axi_writer.sv
module tb_sample_axi_writer;

   localparam logic [31:0] BASE  = 32'h0000_1000;
   localparam int          RING  = 4;
   localparam int          DEPTH = 8;

   logic        clock_50 = 1'b0;
   logic        reset, enable, sample_valid, clear_status;
   logic [13:0] sample_data;
   logic [31:0] awaddr, wdata;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic [3:0]  wstrb;
   logic [1:0]  bresp;
   logic        overflow, bus_error, busy;

   always #10 clock_50 = ~clock_50;

   sample_axi_writer #(
      .BASE_ADDR  (BASE),
      .RING_WORDS (RING),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clock_50     (clock_50),
      .reset        (reset),
      .enable       (enable),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .clear_status (clear_status),
      .awaddr       (awaddr),
      .awvalid      (awvalid),
      .awready      (awready),
      .wdata        (wdata),
      .wstrb        (wstrb),
      .wvalid       (wvalid),
      .wready       (wready),
      .bresp        (bresp),
      .bvalid       (bvalid),
      .bready       (bready),
      .overflow     (overflow),
      .bus_error    (bus_error),
      .busy         (busy)
   );

   int          total = 0, bad = 0, cyc = 0;
   logic [31:0] exp_q[$];
   logic [31:0] aw_q[$], w_q[$];
   logic [17:0] seq_m;
   int          wr_cnt, aw_n, w_n, b_n;
   int          aw_wait, w_wait, b_wait, err_at;
   bit          rnd;
   bit          aw_pend, w_pend, br_prev, pend_err, exp_berr;
   logic [31:0] aw_prev, w_prev, last_addr, last_data;
   int          last_aw_cyc, last_w_cyc, last_br_cyc;

   typedef struct {
      logic [13:0] d;
      logic        en;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
   } vec_t;
   vec_t tbl[7];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // AXI slave with programmable stalls plus the write scoreboard.
   task automatic slave_step();
      logic [31:0] a, d, ea;
      bvalid = 1'b0;
      bresp  = 2'b00;
      if (bready && !br_prev) last_br_cyc = cyc;
      br_prev = bready;
      if (bready) begin
         chk("bready_after_both", 32'((aw_n > b_n) && (w_n > b_n)), 32'd1);
         if (b_wait > 0) begin
            b_wait--;
         end else if (aw_q.size() > 0 && w_q.size() > 0) begin
            bvalid = 1'b1;
            bresp  = (wr_cnt == err_at || (rnd && $urandom_range(0, 7) == 0)) ? 2'b10 : 2'b00;
            pend_err = (bresp != 2'b00);
            a  = aw_q.pop_front();
            d  = w_q.pop_front();
            ea = BASE + 32'(4 * (wr_cnt % RING));
            chk("awaddr", a, ea);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write: got data %h, expected no write (cycle %0d)", d, cyc);
            end else begin
               chk("wdata", d, exp_q.pop_front());
            end
            last_addr = a;
            last_data = d;
            b_n++;
            wr_cnt++;
            b_wait = rnd ? int'($urandom_range(0, 2)) : 0;
         end
      end
      if (awvalid) begin
         if (aw_pend) chk("awaddr_stable", awaddr, aw_prev);
         if (aw_wait == 0) begin
            awready = 1'b1;
            aw_q.push_back(awaddr);
            aw_n++;
            aw_pend = 1'b0;
            last_aw_cyc = cyc;
            aw_wait = rnd ? int'($urandom_range(0, 3)) : 0;
         end else begin
            awready = 1'b0;
            aw_wait--;
            aw_pend = 1'b1;
            aw_prev = awaddr;
         end
      end else begin
         if (aw_pend) chk("awvalid_held", 32'(awvalid), 32'd1);
         awready = 1'b0;
         aw_pend = 1'b0;
      end
      if (wvalid) begin
         if (w_pend) chk("wdata_stable", wdata, w_prev);
         if (w_wait == 0) begin
            wready = 1'b1;
            chk("wstrb", 32'(wstrb), 32'hF);
            w_q.push_back(wdata);
            w_n++;
            w_pend = 1'b0;
            last_w_cyc = cyc;
            w_wait = rnd ? int'($urandom_range(0, 3)) : 0;
         end else begin
            wready = 1'b0;
            w_wait--;
            w_pend = 1'b1;
            w_prev = wdata;
         end
      end else begin
         if (w_pend) chk("wvalid_held", 32'(wvalid), 32'd1);
         wready = 1'b0;
         w_pend = 1'b0;
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      aw_q.delete();
      w_q.delete();
      seq_m = '0;
      wr_cnt = 0; aw_n = 0; w_n = 0; b_n = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0;
      aw_pend = 1'b0; w_pend = 1'b0; br_prev = 1'b0; pend_err = 1'b0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
   endtask

   task automatic tick();
      @(negedge clock_50);
      cyc++;
      if (reset) exp_berr = 1'b0;
      else if (pend_err) exp_berr = 1'b1;
      else if (clear_status) exp_berr = 1'b0;
      pend_err = 1'b0;
      chk("bus_error", 32'(bus_error), 32'(exp_berr));
      sample_valid = 1'b0;
      clear_status = 1'b0;
      slave_step();
   endtask

   task automatic strobe(input logic [13:0] d, input logic en, input bit model);
      sample_valid = 1'b1;
      sample_data  = d;
      enable       = en;
      if (model && en) begin
         exp_q.push_back({seq_m, d});
         seq_m++;
      end
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      chk("drain_timeout", 32'(busy || exp_q.size() != 0), 32'd0);
   endtask

   task automatic do_reset();
      tick();
      reset = 1'b1;
      model_reset();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int  b0;
      bit  found;
      reset = 1'b1; enable = 1'b0; sample_valid = 1'b0; sample_data = '0;
      clear_status = 1'b0; rnd = 1'b0; err_at = -1; exp_berr = 1'b0;
      last_aw_cyc = 0; last_w_cyc = 0; last_br_cyc = 0;
      model_reset();

      tbl[0] = '{14'h0001, 1'b1, 1'b1, BASE + 32'h0, 32'h0000_0001};
      tbl[1] = '{14'h3FFF, 1'b1, 1'b1, BASE + 32'h4, 32'h0000_7FFF};
      tbl[2] = '{14'h0AAA, 1'b0, 1'b0, BASE + 32'h0, 32'h0000_0000};
      tbl[3] = '{14'h1555, 1'b1, 1'b1, BASE + 32'h8, 32'h0000_9555};
      tbl[4] = '{14'h2000, 1'b1, 1'b1, BASE + 32'hC, 32'h0000_E000};
      tbl[5] = '{14'h0000, 1'b1, 1'b1, BASE + 32'h0, 32'h0001_0000};
      tbl[6] = '{14'h1234, 1'b1, 1'b1, BASE + 32'h4, 32'h0001_5234};

      tick(); tick(); tick();
      chk("rst_awvalid", 32'(awvalid), 32'd0);
      chk("rst_wvalid", 32'(wvalid), 32'd0);
      chk("rst_bready", 32'(bready), 32'd0);
      chk("rst_awaddr", awaddr, BASE);
      chk("rst_wdata", wdata, 32'd0);
      chk("rst_wstrb", 32'(wstrb), 32'hF);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      enable = 1'b1;

      // single sample, latency and busy timing
      tick();
      strobe(14'h1ABC, 1'b1, 1'b1);
      b0 = b_n;
      tick();
      chk("lat_awvalid_e0", 32'(awvalid), 32'd0);
      chk("lat_busy_e0", 32'(busy), 32'd1);
      tick();
      chk("lat_awvalid_e1", 32'(awvalid), 32'd1);
      chk("lat_wvalid_e1", 32'(wvalid), 32'd1);
      chk("lat_awaddr", awaddr, BASE);
      chk("lat_wdata", wdata, 32'h0000_1ABC);
      tick();
      chk("lat_bready_e2", 32'(bready), 32'd1);
      chk("lat_awvalid_e2", 32'(awvalid), 32'd0);
      tick();
      chk("lat_busy_e3", 32'(busy), 32'd0);
      chk("lat_writes", 32'(b_n - b0), 32'd1);

      // table: ring wrap, enable gating, word packing
      do_reset();
      for (int i = 0; i < 7; i++) begin
         b0 = b_n;
         tick();
         strobe(tbl[i].d, tbl[i].en, 1'b1);
         tick();
         wait_idle(20);
         chk("tbl_writes", 32'(b_n - b0), 32'(tbl[i].wr));
         if (tbl[i].wr) begin
            chk("tbl_addr", last_addr, tbl[i].addr);
            chk("tbl_data", last_data, tbl[i].data);
         end
      end
      enable = 1'b1;

      // wready three cycles ahead of awready
      aw_wait = 3;
      tick();
      strobe(14'h0777, 1'b1, 1'b1);
      tick();
      wait_idle(30);
      chk("w_before_aw", 32'(last_aw_cyc - last_w_cyc), 32'd3);
      chk("bready_after_aw", 32'(last_br_cyc - last_aw_cyc), 32'd1);

      // error on the second of three writes, then clear
      err_at = wr_cnt + 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         strobe(14'(14'h0200 + i), 1'b1, 1'b1);
      end
      tick();
      wait_idle(40);
      chk("bus_error_set", 32'(bus_error), 32'd1);
      err_at = -1;
      tick();
      clear_status = 1'b1;
      tick();
      chk("bus_error_cleared", 32'(bus_error), 32'd0);

      // error response in the same cycle as clear_status: set wins
      err_at = wr_cnt;
      tick();
      strobe(14'h0321, 1'b1, 1'b1);
      found = 1'b0;
      for (int n = 0; n < 10 && !found; n++) begin
         tick();
         if (bvalid && bresp != 2'b00) begin
            clear_status = 1'b1;
            found = 1'b1;
         end
      end
      chk("err_resp_seen", 32'(found), 32'd1);
      tick();
      chk("set_beats_clear", 32'(bus_error), 32'd1);
      err_at = -1;
      wait_idle(20);
      tick();
      clear_status = 1'b1;
      tick();

      // overflow: 12 back-to-back strobes with awready stalled
      b0 = b_n;
      aw_wait = 20;
      for (int i = 0; i < 12; i++) begin
         tick();
         strobe(14'(14'h0100 + i), 1'b1, i < 9);
      end
      tick();
      wait_idle(100);
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_writes", 32'(b_n - b0), 32'd9);
      tick();
      clear_status = 1'b1;
      tick();
      tick();
      chk("ovf_cleared", 32'(overflow), 32'd0);

      // reset while in XFER
      aw_wait = 10;
      tick();
      strobe(14'h0AAA, 1'b1, 1'b1);
      tick();
      strobe(14'h0BBB, 1'b1, 1'b1);
      found = 1'b0;
      for (int n = 0; n < 10 && !found; n++) begin
         tick();
         found = awvalid;
      end
      chk("xfer_reached", 32'(found), 32'd1);
      reset = 1'b1;
      model_reset();
      tick();
      chk("rstx_awvalid", 32'(awvalid), 32'd0);
      chk("rstx_wvalid", 32'(wvalid), 32'd0);
      chk("rstx_bready", 32'(bready), 32'd0);
      chk("rstx_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      tick();
      strobe(14'h0155, 1'b1, 1'b1);
      tick();
      wait_idle(20);
      chk("rstx_first_addr", last_addr, BASE);
      chk("rstx_first_data", last_data, 32'h0000_0155);

      // randomized traffic against the queue model
      rnd = 1'b1;
      for (int n = 0; n < 400; n++) begin
         tick();
         if ($urandom_range(0, 15) == 0) clear_status = 1'b1;
         if ($urandom_range(0, 9) < 4 && exp_q.size() < DEPTH - 1)
            strobe(14'($urandom), 1'($urandom_range(0, 3) != 0), 1'b1);
      end
      tick();
      wait_idle(300);
      rnd = 1'b0;
      chk("rand_no_overflow", 32'(overflow), 32'd0);
      chk("rand_all_written", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sample_axi_writer.md
# sample_axi_writer

Controller that sequences the 14-bit recovered-sample datapath into memory. It captures strobed samples on `clock_50` into a small FIFO and issues one AXI4-Lite write per sample. Writes go to a circular buffer of 32-bit words at incrementing addresses. It sits between the clock-recovery sampler and the system interconnect, and reports overflow and bus-error status to software.

## Interface
- `BASE_ADDR`, 32'h0000_0000: byte address of ring word 0; must be 4-byte aligned.
- `RING_WORDS`, 1024: ring length in 32-bit words, power of two, ≥2.
- `FIFO_DEPTH`, 8: sample FIFO entries, power of two, ≥2.

Ports:
- `clock_50` in 1: sole clock.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: when low, new samples are ignored; in-flight transaction still completes.
- `sample_valid` in 1: one-cycle strobe, sample present (recovery strobe).
- `sample_data` in 14: sample value.
- `clear_status` in 1: one-cycle pulse, clears `overflow` and `bus_error`.
- `awaddr` out 32, `awvalid` out 1, `awready` in 1: AXI4-Lite write address channel.
- `wdata` out 32, `wstrb` out 4, `wvalid` out 1, `wready` in 1: AXI4-Lite write data channel.
- `bresp` in 2, `bvalid` in 1, `bready` out 1: AXI4-Lite write response channel.
- `overflow` out 1: sticky; a sample was dropped.
- `bus_error` out 1: sticky; a response other than OKAY was received.
- `busy` out 1: FIFO non-empty or transaction in flight.

## Operation
- Capture:
  - Push `sample_data` when `sample_valid && enable`.
  - If the FIFO is full and no pop occurs that cycle, drop the sample and set `overflow`.
  - Push and pop in the same cycle when full: the sample is accepted, nothing is dropped.
- Sequence counter `seq` (18 bit):
  - Increments on each accepted push, wraps 2^18-1 → 0.
  - Stored in the FIFO with the sample.
- Word format:
  - `wdata = {seq[17:0], sample[13:0]}`.
  - `wstrb = 4'hF` constant.
- FSM states: IDLE, XFER, RESP.
  - IDLE: if FIFO non-empty, pop, register `wdata`/`awaddr`, assert `awvalid` and `wvalid` → XFER.
  - XFER:
    - Each valid deasserts after its own handshake (`awvalid&&awready`, `wvalid&&wready`).
    - The two handshakes may occur in the same or different cycles, in either order.
    - When both are done → RESP with `bready=1`.
  - RESP: on `bvalid`:
    - If `bresp != 2'b00`, set `bus_error`.
    - Advance the word index.
    - If FIFO non-empty, pop and launch the next write directly (→ XFER), else → IDLE.
- Addressing:
  - `awaddr = BASE_ADDR + 4*idx`, where idx is a log2(RING_WORDS)-bit index.
  - Wraps RING_WORDS-1 → 0.
  - The index advances on every response, including error responses.
- Status:
  - `clear_status` clears `overflow` and `bus_error`.
  - A set event in the same cycle as `clear_status` wins (flag stays 1).

## Timing
- Reset values:
  - `awvalid`=`wvalid`=`bready`=0.
  - `awaddr`=BASE_ADDR, `wdata`=0, `wstrb`=4'hF.
  - `overflow`=`bus_error`=`busy`=0.
  - FSM IDLE, FIFO empty, idx=0, seq=0.
- Latency: sample strobed at edge E into an empty FIFO with FSM IDLE → `awvalid`/`wvalid` high after edge E+1.
- Valid rules:
  - Valids never drop before their handshake.
  - `awaddr`/`wdata` are stable while valid is high.
- Throughput: best case one write per 2 cycles (XFER 1 cycle, RESP 1 cycle).
- `busy` is registered and reflects state/FIFO after each edge.
- Reset asserted mid-transaction:
  - All valids drop at that edge.
  - The FIFO is flushed; idx and seq return to 0.
  - Usable only when the interconnect is reset in the same cycle.
- `enable` low: samples presented in that cycle are neither pushed nor counted in `seq`.

## Structure
- Shared package `sample_axi_pkg`:
  - `SAMPLE_W`=14, `SEQ_W`=18.
  - `AXI_RESP_OKAY`=2'b00.
  - FSM state enum.
  - Function packing `{seq,sample}`.
- Sub-module `sample_fifo`:
  - Synchronous FIFO, width SEQ_W+SAMPLE_W, parameter FIFO_DEPTH.
  - Ports `push`/`pop`/`full`/`empty`.
  - Supports simultaneous push/pop when full.
- Top level: FSM, address index, status flags.

## Test plan
- Single sample 14'h1ABC at seq 0, immediate awready/wready/bvalid OKAY → one write, `awaddr`=BASE, `wdata`=32'h0000_1ABC, `busy` low 3 cycles after the strobe.
- 12 back-to-back strobes, FIFO_DEPTH=8, `awready` held low 20 cycles → `overflow`=1, exactly 9 writes issued (1 in flight + 8 buffered), seq values contiguous 0–8; the 3 dropped samples consume no seq value.
- `wready` granted 3 cycles before `awready` → each valid held until its own handshake; `bready` asserted only after both handshakes.
- RING_WORDS=4, 6 samples → addresses BASE+0, +4, +8, +C, +0, +4.
- Write 2 answered with `bresp`=2'b10 → `bus_error`=1, next write at idx+1; `clear_status` pulse → `bus_error`=0.
- Reset asserted while in XFER → valids 0 next cycle; first write after reset at BASE with seq 0.
